spi_eep: RTL and testbench

SPI-slave model of the calibration EEPROM on the DSO board, a 64 x 8-bit array.
- It sits on the shared SCLK/MOSI bus, selected by EEP_ss_n from the digital core.
- Each 16-bit frame is either a write (address + data) or a read request.
- The read data is returned on MISO during the following frame.

---
 rtl/eep_pkg.sv | 16 +
 rtl/spi_slave_shift.sv | 104 ++++++++++
 rtl/spi_eep.sv | 89 ++++++++
 tb/tb_spi_eep.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/eep_pkg.sv
// Shared definitions for the calibration EEPROM SPI slave: opcodes, frame geometry and FSM states.
package eep_pkg;

    localparam logic [1:0] OPC_RD     = 2'b00;
    localparam logic [1:0] OPC_WR     = 2'b01;
    localparam int         FRAME_BITS = 16;
    localparam int         DATA_W     = 8;
    localparam int         CNT_W      = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        EXEC  = 2'd2
    } state_e;

endpackage

// File: rtl/spi_slave_shift.sv
// SPI mode-3 slave front end: input synchronisers, edge detection, 16-bit rx/tx shifters and bit counter.
module spi_slave_shift
    import eep_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ss_n,
    input  logic              sclk,
    input  logic              mosi,
    input  logic [DATA_W-1:0] ld_data,
    output logic              miso,
    output logic              frame_start,
    output logic              frame_done,
    output logic              frame_abort,
    output logic [15:0]       rx_data
);

    // One extra stage on SS_n and SCLK holds the previous synchronised sample for edge detection.
    logic [SYNC_STAGES:0]   ss_sync_q, ss_sync_d;
    logic [SYNC_STAGES:0]   sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      rx_q, rx_d;
    logic [15:0]      tx_q, tx_d;
    logic             active_q, active_d;
    logic             first_fall_q, first_fall_d;

    logic ss_lvl, ss_fall, ss_rise, sclk_rise, sclk_fall, mosi_s;

    always_comb begin
        ss_sync_d   = {ss_sync_q[SYNC_STAGES-1:0], ss_n};
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-1:0], sclk};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};

        ss_lvl    = ss_sync_q[SYNC_STAGES-1];
        ss_fall   = ss_sync_q[SYNC_STAGES] & ~ss_sync_q[SYNC_STAGES-1];
        ss_rise   = ~ss_sync_q[SYNC_STAGES] & ss_sync_q[SYNC_STAGES-1];
        sclk_rise = ~sclk_sync_q[SYNC_STAGES] & sclk_sync_q[SYNC_STAGES-1];
        sclk_fall = sclk_sync_q[SYNC_STAGES] & ~sclk_sync_q[SYNC_STAGES-1];
        mosi_s    = mosi_sync_q[SYNC_STAGES-1];

        cnt_d        = cnt_q;
        rx_d         = rx_q;
        tx_d         = tx_q;
        active_d     = active_q;
        first_fall_d = first_fall_q;

        // A frame start outranks any SCLK edge seen on the same cycle.
        if (ss_fall) begin
            cnt_d        = '0;
            rx_d         = '0;
            tx_d         = {8'h00, ld_data};
            active_d     = 1'b1;
            first_fall_d = 1'b1;
        end else if (ss_rise) begin
            active_d = 1'b0;
        end else if (active_q) begin
            if (sclk_rise && (cnt_q != CNT_W'(FRAME_BITS))) begin
                rx_d  = {rx_q[14:0], mosi_s};
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (sclk_fall) begin
                if (first_fall_q) begin
                    first_fall_d = 1'b0;
                end else begin
                    tx_d = {tx_q[14:0], 1'b0};
                end
            end
        end

        frame_start = ss_fall;
        frame_done  = ss_rise & active_q & (cnt_q == CNT_W'(FRAME_BITS));
        frame_abort = ss_rise & active_q & (cnt_q != CNT_W'(FRAME_BITS));
        rx_data     = rx_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ss_sync_q    <= '1;
            sclk_sync_q  <= '1;
            mosi_sync_q  <= '0;
            cnt_q        <= '0;
            rx_q         <= '0;
            tx_q         <= '0;
            active_q     <= 1'b0;
            first_fall_q <= 1'b0;
        end else begin
            ss_sync_q    <= ss_sync_d;
            sclk_sync_q  <= sclk_sync_d;
            mosi_sync_q  <= mosi_sync_d;
            cnt_q        <= cnt_d;
            rx_q         <= rx_d;
            tx_q         <= tx_d;
            active_q     <= active_d;
            first_fall_q <= first_fall_d;
        end
    end

    assign miso = ss_lvl ? 1'bz : tx_q[15];

endmodule

// File: rtl/spi_eep.sv
// Calibration EEPROM (2**ADDR_W x 8) behind a mode-3 SPI slave; read data returns in the following frame.
module spi_eep
    import eep_pkg::*;
#(
    parameter int ADDR_W      = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic SS_n,
    input  logic SCLK,
    input  logic MOSI,
    output logic MISO
);

    localparam int DEPTH = 2 ** ADDR_W;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   rd_buf_q, rd_buf_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                frame_start, frame_done, frame_abort;
    logic [15:0]         rx_data;
    logic [1:0]          opc;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wr_data;
    logic                wr_en;

    spi_slave_shift #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_shift (
        .clk         (clk),
        .rst         (rst_n),
        .ss_n        (SS_n),
        .sclk        (SCLK),
        .mosi        (MOSI),
        .ld_data     (rd_buf_q),
        .miso        (MISO),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .frame_abort (frame_abort),
        .rx_data     (rx_data)
    );

    always_comb begin
        state_d  = state_q;
        rd_buf_d = rd_buf_q;
        wr_en    = 1'b0;
        opc      = rx_data[15:14];
        addr     = rx_data[8 +: ADDR_W];
        wr_data  = rx_data[DATA_W-1:0];

        case (state_q)
            IDLE: begin
                if (frame_start) state_d = SHIFT;
            end
            SHIFT: begin
                if (frame_done)       state_d = EXEC;
                else if (frame_abort) state_d = IDLE;
            end
            EXEC: begin
                // rx_data still holds the completed frame; it is only cleared at the next SS_n fall.
                state_d = IDLE;
                if (opc == OPC_WR)      wr_en    = 1'b1;
                else if (opc == OPC_RD) rd_buf_d = mem_q[addr];
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q  <= IDLE;
            rd_buf_q <= '0;
        end else begin
            state_q  <= state_d;
            rd_buf_q <= rd_buf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_spi_eep.sv
// Directed bench for spi_eep: drives mode-3 SPI frames and checks the data returned on MISO.
module tb_spi_eep;
    import eep_pkg::*;

    localparam int HALF = 10;

    logic clk = 1'b0;
    logic rst_n, SS_n, SCLK, MOSI;
    wire  MISO;

    int vectors = 0;
    int miscompares = 0;

    // The pull makes a released MISO read as 1, while every driven bit [15:8] is 0.
    pullup (MISO);

    spi_eep dut (
        .clk   (clk),
        .rst_n (rst_n),
        .SS_n  (SS_n),
        .SCLK  (SCLK),
        .MOSI  (MOSI),
        .MISO  (MISO)
    );

    always #5 clk = ~clk;

    task automatic sclk_bit(input logic b, output logic so);
        SCLK = 1'b0;
        MOSI = b;
        repeat (HALF) @(negedge clk);
        so   = MISO;
        SCLK = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic xfer(input logic [15:0] w, input int nbits, input int gap,
                        output logic [15:0] rdata);
        logic so;
        logic b;
        rdata = '0;
        SS_n  = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            b = (i < 16) ? w[15 - i] : 1'b0;
            sclk_bit(b, so);
            if (i < 16) rdata[15 - i] = so;
        end
        SS_n = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic check16(input string name, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset;
        logic [15:0] r;
        rst_n = 1'b1; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if (dut.state_q !== IDLE) begin
            miscompares++;
            $display("FAIL reset_state: got %0d expected %0d", dut.state_q, IDLE);
        end
        vectors++;
        if (MISO !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_miso_released: got %b expected 1 (pulled)", MISO);
        end
        xfer(16'h3F00, 16, 20, r);
        check16("reset_read3f_frame", r, 16'h0000);
        xfer(16'hC000, 16, 20, r);
        check16("reset_mem3f", r, 16'h0000);
        vectors++;
        if (MISO !== 1'b1) begin
            miscompares++;
            $display("FAIL idle_miso_released: got %b expected 1 (pulled)", MISO);
        end
    endtask

    task automatic test_write_read;
        logic [15:0] r;
        xfer(16'h4680, 16, 20, r);
        check16("wr6_frame", r, 16'h0000);
        xfer(16'h4702, 16, 20, r);
        check16("wr7_frame", r, 16'h0000);
        xfer(16'h0600, 16, 20, r);
        check16("rd6_frame", r, 16'h0000);
        xfer(16'hC000, 16, 20, r);
        check16("rd6_data", r, 16'h0080);
        xfer(16'h0700, 16, 20, r);
        check16("rd7_frame", r, 16'h0080);
        xfer(16'hC000, 16, 20, r);
        check16("rd7_data", r, 16'h0002);
    endtask

    task automatic test_abort;
        logic [15:0] r;
        xfer(16'h4655, 10, 20, r);
        check16("abort_frame_bits", r, 16'h0000);
        xfer(16'h0600, 16, 20, r);
        check16("abort_rdbuf_kept", r, 16'h0002);
        xfer(16'hC000, 16, 20, r);
        check16("abort_mem6_kept", r, 16'h0080);
    endtask

    task automatic test_overlong_noop;
        logic [15:0] r;
        xfer(16'h4511, 20, 20, r);
        check16("overlong_frame", r, 16'h0080);
        xfer(16'h0600, 16, 20, r);
        check16("rd6_before_noop", r, 16'h0080);
        xfer(16'hC5FF, 16, 20, r);
        check16("noop_frame", r, 16'h0080);
        xfer(16'hC000, 16, 20, r);
        check16("noop_rdbuf_kept", r, 16'h0080);
        xfer(16'h0500, 16, 20, r);
        check16("rd5_frame", r, 16'h0080);
        xfer(16'hC000, 16, 20, r);
        check16("mem5_after_noop", r, 16'h0011);
    endtask

    task automatic test_back_to_back;
        logic [15:0] r;
        xfer(16'h0600, 16, 6, r);
        check16("b2b_first", r, 16'h0011);
        xfer(16'h0700, 16, 6, r);
        check16("b2b_second", r, 16'h0080);
        xfer(16'hC000, 16, 20, r);
        check16("b2b_third", r, 16'h0002);
    endtask

    task automatic test_reset_mid_frame;
        logic [15:0] r;
        logic [15:0] w;
        logic so;
        w = 16'h4955;
        SS_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < 8; i++) sclk_bit(w[15 - i], so);
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        vectors++;
        if (dut.state_q !== IDLE) begin
            miscompares++;
            $display("FAIL midreset_state: got %0d expected %0d", dut.state_q, IDLE);
        end
        vectors++;
        if (MISO !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_miso_released: got %b expected 1 (pulled)", MISO);
        end
        for (int i = 8; i < 16; i++) sclk_bit(w[15 - i], so);
        SS_n = 1'b1;
        repeat (20) @(negedge clk);
        xfer(16'h0900, 16, 20, r);
        check16("midreset_rdbuf_cleared", r, 16'h0000);
        xfer(16'hC000, 16, 20, r);
        check16("midreset_mem9", r, 16'h0000);
        xfer(16'h0600, 16, 20, r);
        check16("midreset_rd6_frame", r, 16'h0000);
        xfer(16'hC000, 16, 20, r);
        check16("midreset_mem6_cleared", r, 16'h0000);
        xfer(16'h49AA, 16, 20, r);
        xfer(16'h0900, 16, 20, r);
        xfer(16'hC000, 16, 20, r);
        check16("post_reset_wr9_rd9", r, 16'h00AA);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_abort();
        test_overlong_noop();
        test_back_to_back();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
